// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with two combinational read ports,
// one synchronous write port, optional write-through bypass, optional
// hardwired zero register and a per-register busy scoreboard.
module reg_file_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  DataIn,
    input  logic              Write,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [ADDR_W-1:0] ReadAddrA,
    input  logic [ADDR_W-1:0] ReadAddrB,
    output logic [WIDTH-1:0]  ReadDataA,
    output logic [WIDTH-1:0]  ReadDataB,
    input  logic              SetBusy,
    input  logic [ADDR_W-1:0] SetBusyAddr,
    output logic              BusyA,
    output logic              BusyB,
    output logic              AnyBusy
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             any_busy_q;

    logic             wr_ok;
    logic             set_ok;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] set_hit;

    // True when the address names a real register that can hold state
    // (in range, and not the hardwired zero register).
    function automatic logic live(input logic [ADDR_W-1:0] a);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    assign wr_ok  = Write & live(WriteAddr);
    assign set_ok = SetBusy & live(SetBusyAddr);

    // Decode write/set targets and form next busy vector; a set beats a clear.
    always_comb begin
        wr_hit  = '0;
        set_hit = '0;
        busy_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit[i]  = wr_ok  && (WriteAddr   == ADDR_W'(i));
            set_hit[i] = set_ok && (SetBusyAddr == ADDR_W'(i));
            busy_d[i]  = set_hit[i] | (busy_q[i] & ~wr_hit[i]);
        end
    end

    // Register storage: only decoded, valid write targets are updated.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    regs_q[i] <= DataIn;
                end
            end
        end
    end

    // Scoreboard state and registered any-busy summary of the next state.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            busy_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            any_busy_q <= |busy_d;
        end
    end

    // Read ports: stored lookup, then same-cycle forwarding of a valid write.
    // Forwarding is not gated by Reset so a write issued during reset is
    // still visible combinationally even though it is never captured.
    always_comb begin
        ReadDataA = '0;
        ReadDataB = '0;
        BusyA     = 1'b0;
        BusyB     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
                if (ReadAddrA == ADDR_W'(i)) begin
                    ReadDataA = regs_q[i];
                    BusyA     = busy_q[i];
                end
                if (ReadAddrB == ADDR_W'(i)) begin
                    ReadDataB = regs_q[i];
                    BusyB     = busy_q[i];
                end
            end
        end
        if (BYPASS != 0 && wr_ok && WriteAddr == ReadAddrA) begin
            ReadDataA = DataIn;
            if (!(set_ok && SetBusyAddr == ReadAddrA)) begin
                BusyA = 1'b0;
            end
        end
        if (BYPASS != 0 && wr_ok && WriteAddr == ReadAddrB) begin
            ReadDataB = DataIn;
            if (!(set_ok && SetBusyAddr == ReadAddrB)) begin
                BusyB = 1'b0;
            end
        end
    end

    assign AnyBusy = any_busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb: four parameterisations share one
// stimulus stream (default, no-bypass, zero-register, 32x6 odd depth).
module tb_reg_file_sb;

    logic        CLK;
    logic        Reset;
    logic [31:0] d32;
    logic        Write;
    logic [2:0]  WriteAddr;
    logic [2:0]  ReadAddrA;
    logic [2:0]  ReadAddrB;
    logic        SetBusy;
    logic [2:0]  SetBusyAddr;

    logic [15:0] def_rda, def_rdb, nb_rda, nb_rdb, z_rda, z_rdb;
    logic [31:0] w_rda, w_rdb;
    logic        def_ba, def_bb, def_any;
    logic        nb_ba, nb_bb, nb_any;
    logic        z_ba, z_bb, z_any;
    logic        w_ba, w_bb, w_any;

    int n_cmp;
    int n_err;

    reg_file_sb u_def (
        .CLK(CLK), .Reset(Reset), .DataIn(d32[15:0]), .Write(Write),
        .WriteAddr(WriteAddr), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
        .ReadDataA(def_rda), .ReadDataB(def_rdb), .SetBusy(SetBusy),
        .SetBusyAddr(SetBusyAddr), .BusyA(def_ba), .BusyB(def_bb), .AnyBusy(def_any)
    );

    reg_file_sb #(.BYPASS(0)) u_nb (
        .CLK(CLK), .Reset(Reset), .DataIn(d32[15:0]), .Write(Write),
        .WriteAddr(WriteAddr), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
        .ReadDataA(nb_rda), .ReadDataB(nb_rdb), .SetBusy(SetBusy),
        .SetBusyAddr(SetBusyAddr), .BusyA(nb_ba), .BusyB(nb_bb), .AnyBusy(nb_any)
    );

    reg_file_sb #(.ZERO_REG(1)) u_z (
        .CLK(CLK), .Reset(Reset), .DataIn(d32[15:0]), .Write(Write),
        .WriteAddr(WriteAddr), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
        .ReadDataA(z_rda), .ReadDataB(z_rdb), .SetBusy(SetBusy),
        .SetBusyAddr(SetBusyAddr), .BusyA(z_ba), .BusyB(z_bb), .AnyBusy(z_any)
    );

    reg_file_sb #(.WIDTH(32), .DEPTH(6), .ADDR_W(3)) u_w (
        .CLK(CLK), .Reset(Reset), .DataIn(d32), .Write(Write),
        .WriteAddr(WriteAddr), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
        .ReadDataA(w_rda), .ReadDataB(w_rdb), .SetBusy(SetBusy),
        .SetBusyAddr(SetBusyAddr), .BusyA(w_ba), .BusyB(w_bb), .AnyBusy(w_any)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 2 time units after it, well away from the edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        Reset       = 1'b1;
        d32         = '0;
        Write       = 1'b0;
        WriteAddr   = '0;
        ReadAddrA   = '0;
        ReadAddrB   = '0;
        SetBusy     = 1'b0;
        SetBusyAddr = '0;

        // Reset state
        #1;
        chk("rst_rda", def_rda, 32'h0);
        chk("rst_any", def_any, 32'h0);
        tick();
        tick();
        Reset = 1'b0;

        // Sweep: reg i <- i, reg 0 <- FFFF
        for (int i = 0; i < 8; i++) begin
            Write     = 1'b1;
            WriteAddr = 3'(i);
            d32       = (i == 0) ? 32'h0000_FFFF : 32'(i);
            tick();
        end
        Write = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ReadAddrA = 3'(i);
            ReadAddrB = 3'(7 - i);
            #1;
            chk($sformatf("sweep_a%0d", i), def_rda, (i == 0) ? 32'hFFFF : 32'(i));
            chk($sformatf("sweep_b%0d", 7 - i), def_rdb, (7 - i == 0) ? 32'hFFFF : 32'(7 - i));
        end
        ReadAddrA = 3'd0;
        #1;
        chk("zr_sweep_a0", z_rda, 32'h0);

        // Bypass vs no bypass on register 3 (old value 3)
        Write     = 1'b1;
        WriteAddr = 3'd3;
        d32       = 32'h0000_A5A5;
        ReadAddrA = 3'd3;
        #1;
        chk("byp_pre", def_rda, 32'hA5A5);
        chk("nobyp_pre", nb_rda, 32'h0003);
        tick();
        Write = 1'b0;
        #1;
        chk("nobyp_post", nb_rda, 32'hA5A5);

        // Zero register
        Write     = 1'b1;
        WriteAddr = 3'd0;
        d32       = 32'h0000_BEEF;
        ReadAddrA = 3'd0;
        #1;
        chk("zr_wr_pre", z_rda, 32'h0);
        chk("def_r0_byp", def_rda, 32'hBEEF);
        tick();
        Write = 1'b0;
        #1;
        chk("zr_wr_post", z_rda, 32'h0);
        chk("def_r0_post", def_rda, 32'hBEEF);
        SetBusy     = 1'b1;
        SetBusyAddr = 3'd0;
        tick();
        SetBusy = 1'b0;
        #1;
        chk("zr_busy", z_ba, 32'h0);
        chk("zr_any", z_any, 32'h0);
        chk("def_busy0", def_ba, 32'h1);
        chk("def_any0", def_any, 32'h1);
        Write     = 1'b1;
        WriteAddr = 3'd0;
        d32       = 32'h0000_BEEF;
        tick();
        Write = 1'b0;
        #1;
        chk("def_any0_clr", def_any, 32'h0);

        // Scoreboard on register 5
        SetBusy     = 1'b1;
        SetBusyAddr = 3'd5;
        ReadAddrA   = 3'd5;
        #1;
        chk("sb_pre_set", def_ba, 32'h0);
        tick();
        SetBusy = 1'b0;
        #1;
        chk("sb_busy5", def_ba, 32'h1);
        chk("sb_any5", def_any, 32'h1);
        Write       = 1'b1;
        WriteAddr   = 3'd5;
        d32         = 32'h0000_1111;
        SetBusy     = 1'b1;
        SetBusyAddr = 3'd5;
        #1;
        chk("sb_setwin_pre", def_ba, 32'h1);
        tick();
        Write   = 1'b0;
        SetBusy = 1'b0;
        #1;
        chk("sb_setwin_busy", def_ba, 32'h1);
        chk("sb_setwin_data", def_rda, 32'h1111);
        chk("sb_setwin_any", def_any, 32'h1);
        Write     = 1'b1;
        WriteAddr = 3'd5;
        d32       = 32'h0000_2222;
        #1;
        chk("sb_clr_byp", def_ba, 32'h0);
        chk("sb_clr_nobyp", nb_ba, 32'h1);
        chk("sb_clr_any_pre", def_any, 32'h1);
        tick();
        Write = 1'b0;
        #1;
        chk("sb_clr_any", def_any, 32'h0);
        chk("sb_clr_busy", def_ba, 32'h0);
        chk("sb_clr_data", def_rda, 32'h2222);

        // Asynchronous reset between edges
        SetBusy     = 1'b1;
        SetBusyAddr = 3'd2;
        tick();
        SetBusy   = 1'b0;
        ReadAddrA = 3'd2;
        ReadAddrB = 3'd7;
        #1;
        chk("ar_pre_busy", def_ba, 32'h1);
        chk("ar_pre_rda", def_rda, 32'h0002);
        chk("ar_pre_rdb", def_rdb, 32'h0007);
        Reset = 1'b1;
        #1;
        chk("ar_rda", def_rda, 32'h0);
        chk("ar_rdb", def_rdb, 32'h0);
        chk("ar_busy", def_ba, 32'h0);
        chk("ar_any", def_any, 32'h0);
        chk("ar_w_rda", w_rda, 32'h0);
        #1;
        Reset = 1'b0;

        // Odd depth: 32-bit x 6
        Write     = 1'b1;
        WriteAddr = 3'd6;
        d32       = 32'h1234_5678;
        ReadAddrA = 3'd6;
        ReadAddrB = 3'd5;
        #1;
        chk("w_oor_nobyp", w_rda, 32'h0);
        tick();
        Write     = 1'b0;
        ReadAddrB = 3'd7;
        #1;
        chk("w_rd6", w_rda, 32'h0);
        chk("w_rd7", w_rdb, 32'h0);
        Write     = 1'b1;
        WriteAddr = 3'd5;
        ReadAddrA = 3'd5;
        #1;
        chk("w_byp5", w_rda, 32'h1234_5678);
        tick();
        Write = 1'b0;
        #1;
        chk("w_rd5", w_rda, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file with write-through bypass, optional hardwired zero register and a per-register busy scoreboard. It is the generalised successor of the fixed 16-bit × 8 register file used in the datapath. It supplies two combinational read ports and one synchronous write port to the decode stage. The scoreboard lets the control unit stall on registers that still await a pending result.

## Interface
Parameters:
- WIDTH, 16, data width in bits (≥1)
- DEPTH, 8, number of registers (2..2^ADDR_W)
- ADDR_W, 3, address width in bits
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never goes busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- CLK  input  1  clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- DataIn  input  WIDTH  write data
- Write  input  1  write enable
- WriteAddr  input  ADDR_W  write address
- ReadAddrA  input  ADDR_W  read port A address
- ReadAddrB  input  ADDR_W  read port B address
- ReadDataA  output  WIDTH  read port A data (combinational)
- ReadDataB  output  WIDTH  read port B data (combinational)
- SetBusy  input  1  mark a register as awaiting a result
- SetBusyAddr  input  ADDR_W  register to mark busy
- BusyA  output  1  busy status of ReadAddrA (combinational)
- BusyB  output  1  busy status of ReadAddrB (combinational)
- AnyBusy  output  1  registered OR of all busy bits

## Operation
- Storage: DEPTH × WIDTH registers plus DEPTH busy bits.
- Write: on a rising edge with Write=1 and WriteAddr<DEPTH, reg[WriteAddr] ← DataIn.
  - Ignored when WriteAddr≥DEPTH.
  - Ignored when ZERO_REG=1 and WriteAddr=0.
- Read: ReadDataX = reg[ReadAddrX], a purely combinational lookup.
  - Returns 0 when ReadAddrX≥DEPTH.
  - Returns 0 when ZERO_REG=1 and ReadAddrX=0.
- Bypass (BYPASS=1): if Write=1 and WriteAddr=ReadAddrX and the write is valid, ReadDataX=DataIn in the same cycle.
  - A zero register or out-of-range address never forwards.
  - BYPASS=0: the read returns the stored (old) value until the edge.
- Scoreboard, per register i, at each rising edge:
  - busy[i] is set if SetBusy=1 and SetBusyAddr=i.
  - Otherwise busy[i] is cleared if Write=1 and WriteAddr=i.
  - Otherwise busy[i] holds.
- Set and clear on the same register in the same cycle: set wins. The new producer supersedes the completing one, but the data is still written.
- SetBusy to an out-of-range address, or to register 0 with ZERO_REG=1, is ignored.
- BusyX = busy[ReadAddrX]. With BYPASS=1 it is forced to 0 when a valid write to ReadAddrX occurs that cycle and no same-cycle SetBusy targets that register.
- AnyBusy = registered OR-reduction of the next-state busy vector. It is valid one edge after any change, with no combinational path from inputs.

## Timing
- Reset asserted, at any time including mid-write: all registers = 0, all busy = 0, AnyBusy = 0, immediately (asynchronous).
  - While Reset=1, writes and SetBusy are ignored.
  - Read outputs reflect zeros. Bypass is still active on ReadData when BYPASS=1.
- Reset deassertion: the first capturing edge is the first rising CLK edge with Reset=0.
- Write latency: data is visible on a non-bypassed read immediately after the capturing edge.
- Bypass latency: 0 cycles.
- Busy latency:
  - SetBusy at edge n → BusyX=1 after edge n.
  - Clearing write at edge m → BusyX=0 after edge m, or during cycle m with BYPASS=1.
- Both read ports are independent. Identical addresses on A and B return identical data and busy.
- Parameter-combination sizing: DEPTH<2^ADDR_W must be handled without X on outputs.

## Test plan
- Reset then sweep, defaults:
  - Reset high 2 cycles, release.
  - Write reg i ← i for i=1..7 and reg 0 ← 16'hFFFF.
  - Read all 8 addresses on A and B → exact values, and 16'hFFFF on address 0.
- Bypass:
  - Write=1, WriteAddr=3, DataIn=16'hA5A5, ReadAddrA=3, old value 3 → ReadDataA=16'hA5A5 before the edge.
  - Same with BYPASS=0 → ReadDataA=3 before the edge and 16'hA5A5 after.
- Zero register, ZERO_REG=1:
  - Write 16'hBEEF to address 0 → reads 0.
  - SetBusy addr 0 → BusyA=0 and AnyBusy=0.
- Scoreboard:
  - SetBusy addr 5 → BusyA(5)=1 and AnyBusy=1 next cycle.
  - Write addr 5 with SetBusy addr 5 in the same cycle → busy stays 1 and data updates.
  - Plain write addr 5 → BusyA=0 during that cycle (bypass) and AnyBusy=0 after the edge.
- Asynchronous reset mid-operation:
  - Regs loaded, busy[2]=1.
  - Pulse Reset between clock edges → all reads 0, BusyX=0 and AnyBusy=0 without waiting for CLK.
- Non-power-of-two depth, WIDTH=32, DEPTH=6, ADDR_W=3:
  - Write 32'h12345678 to address 6 → ignored.
  - Read addresses 6 and 7 → 0, no X.
  - Address 5 behaves normally.
